// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared definitions for the multi-channel PWM engine.
//   - register address map as seen through the register bridge
//   - CTRL / STATUS bit positions
//   - reset constants
//   - main counter direction type
//   - address-decode helper for the per-channel DUTY block
// Optional feature macro used by the core: PWM_CENTER_ALIGN_EN.
package pwm_multi_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_PSC       = 8'h01;
  localparam logic [7:0] ADDR_PERIOD    = 8'h02;
  localparam logic [7:0] ADDR_DT        = 8'h03;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_DUTY_BASE = 8'h10;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_FORCE_BIT  = 1;
  localparam int CTRL_CENTER_BIT = 2;
  localparam int STATUS_UPD_BIT  = 0;

  localparam logic [15:0] RST_REG    = 16'h0000;
  localparam logic [15:0] RST_PERIOD = 16'hFFFF;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  // True when addr selects DUTY[n].
  function automatic logic duty_hit(input logic [7:0] addr, input int n);
    return addr == (ADDR_DUTY_BASE + 8'(n));
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: dead-time insertion for one complementary output pair.
//   Every edge of raw_i forces both outputs low and (re)loads a countdown
//   with dt_i.  When the countdown expires, a_o follows raw_i and b_o its
//   complement.  Pulses shorter than the dead time are therefore swallowed.
//   With dt_i == 0, b_o is the exact complement of a_o.
// Ports:
//   clk_i   - clock
//   rst_n_i - asynchronous active-low reset (outputs low)
//   raw_i   - unregistered compare result for this channel
//   dt_i    - dead time in clk_i cycles
//   a_o     - high-side output (registered)
//   b_o     - low-side output (registered)
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                raw_i,
  input  logic [DT_WIDTH-1:0] dt_i,
  output logic                a_o,
  output logic                b_o
);

  localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);

  logic                raw_q_r;
  logic [DT_WIDTH-1:0] dt_cnt_r;
  logic [DT_WIDTH-1:0] dt_cnt_s;
  logic                a_r;
  logic                b_r;
  logic                a_s;
  logic                b_s;

  // Next dead-time count and next output pair.
  always_comb begin
    dt_cnt_s = dt_cnt_r;
    a_s      = raw_i;
    b_s      = ~raw_i;
    if (raw_i != raw_q_r) begin
      // Edge: restart the gap; a zero gap passes the new level straight on.
      dt_cnt_s = dt_i;
      if (dt_i != '0) begin
        a_s = 1'b0;
        b_s = 1'b0;
      end else begin
        a_s = raw_i;
        b_s = ~raw_i;
      end
    end else if (dt_cnt_r != '0) begin
      dt_cnt_s = dt_cnt_r - DT_ONE;
      // The last count of the gap already releases the outputs.
      if (dt_cnt_r != DT_ONE) begin
        a_s = 1'b0;
        b_s = 1'b0;
      end else begin
        a_s = raw_i;
        b_s = ~raw_i;
      end
    end else begin
      dt_cnt_s = '0;
    end
  end

  // Compare register, dead-time counter and output pair registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      raw_q_r  <= 1'b0;
      dt_cnt_r <= '0;
      a_r      <= 1'b0;
      b_r      <= 1'b0;
    end else begin
      raw_q_r  <= raw_i;
      dt_cnt_r <= dt_cnt_s;
      a_r      <= a_s;
      b_r      <= b_s;
    end
  end

  assign a_o = a_r;
  assign b_o = b_r;

endmodule

// File: rtl/pwm_multi_core.sv
// pwm_multi_core: parametrised multi-channel PWM engine behind the register
// bridge.  Shared prescaler and period counter, shadowed PERIOD/DUTY loaded
// at the period boundary, CH_NUM complementary pairs with dead time.
// Optional feature: define PWM_CENTER_ALIGN_EN to make CTRL[2] select an
// up-down (center-aligned) counter; otherwise CTRL[2] reads 0.
// Ports:
//   clk_i     - clock
//   rst_n_i   - asynchronous active-low reset
//   addr_i    - register address
//   wdata_i   - write data
//   wr_en_i   - one-cycle write strobe
//   rd_en_i   - one-cycle read strobe
//   rdata_o   - read data, registered, held until the next read
//   core_en_o - mirror of CTRL.EN
//   update_o  - one-cycle pulse per shadow load event
//   pwm_a_o   - high-side outputs, bit n = channel n
//   pwm_b_o   - low-side outputs, bit n = channel n
module pwm_multi_core
  import pwm_multi_pkg::*;
#(
  parameter int CH_NUM   = 8,
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [7:0]        addr_i,
  input  logic [15:0]       wdata_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  output logic [15:0]       rdata_o,
  output logic              core_en_o,
  output logic              update_o,
  output logic [CH_NUM-1:0] pwm_a_o,
  output logic [CH_NUM-1:0] pwm_b_o
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic                ctrl_en_r;
  logic                force_r;
  logic [WIDTH-1:0]    psc_r;
  logic [WIDTH-1:0]    period_r;
  logic [DT_WIDTH-1:0] dt_r;
  logic                upd_flag_r;
  logic [WIDTH-1:0]    duty_r    [CH_NUM];
  logic [WIDTH-1:0]    period_sh_r;
  logic [WIDTH-1:0]    duty_sh_r [CH_NUM];
`ifdef PWM_CENTER_ALIGN_EN
  logic                ctrl_center_r;
`endif

  logic [WIDTH-1:0]    psc_cnt_r;
  logic [WIDTH-1:0]    psc_cnt_s;
  logic [WIDTH-1:0]    cnt_r;
  logic [WIDTH-1:0]    cnt_s;
  cnt_dir_e            dir_r;
  cnt_dir_e            dir_s;
  logic                wrap_s;
  logic                update_evt_s;
  logic                update_r;

  logic                wr_ctrl_s;
  logic                wr_psc_s;
  logic                wr_period_s;
  logic                wr_dt_s;
  logic                wr_status_s;
  logic [WIDTH-1:0]    duty_rd_s;
  logic [15:0]         rd_s;
  logic [15:0]         rdata_r;
  logic [CH_NUM-1:0]   raw_s;
  logic [CH_NUM-1:0]   dt_a_s;
  logic [CH_NUM-1:0]   dt_b_s;

  assign wr_ctrl_s   = wr_en_i && (addr_i == ADDR_CTRL);
  assign wr_psc_s    = wr_en_i && (addr_i == ADDR_PSC);
  assign wr_period_s = wr_en_i && (addr_i == ADDR_PERIOD);
  assign wr_dt_s     = wr_en_i && (addr_i == ADDR_DT);
  assign wr_status_s = wr_en_i && (addr_i == ADDR_STATUS);

  // Control and timing preload registers; FORCE_UPD is a one-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_en_r     <= 1'b0;
      force_r       <= 1'b0;
      psc_r         <= RST_REG[WIDTH-1:0];
      period_r      <= RST_PERIOD[WIDTH-1:0];
      dt_r          <= RST_REG[DT_WIDTH-1:0];
`ifdef PWM_CENTER_ALIGN_EN
      ctrl_center_r <= 1'b0;
`endif
    end else begin
      force_r <= wr_ctrl_s & wdata_i[CTRL_FORCE_BIT];
      if (wr_ctrl_s) begin
        ctrl_en_r     <= wdata_i[CTRL_EN_BIT];
`ifdef PWM_CENTER_ALIGN_EN
        ctrl_center_r <= wdata_i[CTRL_CENTER_BIT];
`endif
      end
      if (wr_psc_s) begin
        psc_r <= wdata_i[WIDTH-1:0];
      end
      if (wr_period_s) begin
        period_r <= wdata_i[WIDTH-1:0];
      end
      if (wr_dt_s) begin
        dt_r <= wdata_i[DT_WIDTH-1:0];
      end
    end
  end

  // Per-channel DUTY preload registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < CH_NUM; n++) begin
        duty_r[n] <= RST_REG[WIDTH-1:0];
      end
    end else begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (wr_en_i && duty_hit(addr_i, n)) begin
          duty_r[n] <= wdata_i[WIDTH-1:0];
        end
      end
    end
  end

  // Sticky update flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      upd_flag_r <= 1'b0;
    end else if (update_evt_s) begin
      upd_flag_r <= 1'b1;
    end else if (wr_status_s && wdata_i[STATUS_UPD_BIT]) begin
      upd_flag_r <= 1'b0;
    end
  end

  // Prescaler and main counter next state; flags the period wrap.
  always_comb begin
    psc_cnt_s = psc_cnt_r;
    cnt_s     = cnt_r;
    dir_s     = dir_r;
    wrap_s    = 1'b0;
    if (!ctrl_en_r || force_r) begin
      psc_cnt_s = '0;
      cnt_s     = '0;
      dir_s     = DIR_UP;
    end else if (psc_cnt_r >= psc_r) begin
      psc_cnt_s = '0;
`ifdef PWM_CENTER_ALIGN_EN
      if (ctrl_center_r) begin
        case (dir_r)
          DIR_UP: begin
            if (cnt_r >= period_sh_r) begin
              // A period of 0 or 1 has no interior down-count values.
              if (period_sh_r <= ONE_W) begin
                cnt_s  = '0;
                wrap_s = 1'b1;
              end else begin
                cnt_s = cnt_r - ONE_W;
                dir_s = DIR_DOWN;
              end
            end else begin
              cnt_s = cnt_r + ONE_W;
            end
          end
          DIR_DOWN: begin
            // Reaching 0 on the way down is the period boundary.
            if (cnt_r <= ONE_W) begin
              cnt_s  = '0;
              dir_s  = DIR_UP;
              wrap_s = 1'b1;
            end else begin
              cnt_s = cnt_r - ONE_W;
            end
          end
          default: begin
            cnt_s = '0;
            dir_s = DIR_UP;
          end
        endcase
      end else begin
        dir_s = DIR_UP;
        if (cnt_r >= period_sh_r) begin
          cnt_s  = '0;
          wrap_s = 1'b1;
        end else begin
          cnt_s = cnt_r + ONE_W;
        end
      end
`else
      dir_s = DIR_UP;
      // >= keeps the counter bounded even if it ever sits above the top.
      if (cnt_r >= period_sh_r) begin
        cnt_s  = '0;
        wrap_s = 1'b1;
      end else begin
        cnt_s = cnt_r + ONE_W;
      end
`endif
    end else begin
      psc_cnt_s = psc_cnt_r + ONE_W;
    end
  end

  assign update_evt_s = wrap_s | force_r;

  // Counter state registers and update pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_cnt_r <= '0;
      cnt_r     <= '0;
      dir_r     <= DIR_UP;
      update_r  <= 1'b0;
    end else begin
      psc_cnt_r <= psc_cnt_s;
      cnt_r     <= cnt_s;
      dir_r     <= dir_s;
      update_r  <= update_evt_s;
    end
  end

  // Shadows follow the preloads while disabled, otherwise load on update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period_sh_r <= '0;
      for (int n = 0; n < CH_NUM; n++) begin
        duty_sh_r[n] <= '0;
      end
    end else if (!ctrl_en_r || update_evt_s) begin
      period_sh_r <= period_r;
      for (int n = 0; n < CH_NUM; n++) begin
        duty_sh_r[n] <= duty_r[n];
      end
    end
  end

  // Raw compare per channel; registered inside the dead-time stage.
  always_comb begin
    raw_s = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      raw_s[n] = ctrl_en_r & (cnt_r < duty_sh_r[n]);
    end
  end

  // Read-data multiplexer; unmapped addresses return 0.
  always_comb begin
    duty_rd_s = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      duty_rd_s = duty_rd_s | (duty_hit(addr_i, n) ? duty_r[n] : '0);
    end
    rd_s = 16'h0000;
    case (addr_i)
      ADDR_CTRL: begin
        rd_s[CTRL_EN_BIT] = ctrl_en_r;
`ifdef PWM_CENTER_ALIGN_EN
        rd_s[CTRL_CENTER_BIT] = ctrl_center_r;
`endif
      end
      ADDR_PSC:    rd_s[WIDTH-1:0]    = psc_r;
      ADDR_PERIOD: rd_s[WIDTH-1:0]    = period_r;
      ADDR_DT:     rd_s[DT_WIDTH-1:0] = dt_r;
      ADDR_STATUS: rd_s[STATUS_UPD_BIT] = upd_flag_r;
      default:     rd_s[WIDTH-1:0]    = duty_rd_s;
    endcase
  end

  // Read data register, captured on the read strobe only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_r <= 16'h0000;
    end else if (rd_en_i) begin
      rdata_r <= rd_s;
    end
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    pwm_deadtime #(
      .DT_WIDTH (DT_WIDTH)
    ) u_deadtime (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .raw_i   (raw_s[n]),
      .dt_i    (dt_r),
      .a_o     (dt_a_s[n]),
      .b_o     (dt_b_s[n])
    );
  end

  // While disabled the low side would sit high on a zero compare; mask both.
  assign pwm_a_o   = dt_a_s & {CH_NUM{ctrl_en_r}};
  assign pwm_b_o   = dt_b_s & {CH_NUM{ctrl_en_r}};
  assign rdata_o   = rdata_r;
  assign core_en_o = ctrl_en_r;
  assign update_o  = update_r;

endmodule
